// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter sequencer.
//   pc_state_e       : sequencer FSM states (BOOT, RUN, HALT)
//   PC_W             : PC / instruction / counter width
//   PC_STEP          : sequential fetch increment
//   PC_RESET_DEFAULT : default program entry point
//   PC_HALT_INS      : default halting instruction (ecall)
//   COUNT_MAX        : saturation value of the fetch counter
//   word_align()     : clears the byte-offset bits of an address
package pc_pkg;

   localparam int unsigned PC_W = 32;

   localparam logic [PC_W-1:0] PC_STEP          = PC_W'(4);
   localparam logic [PC_W-1:0] PC_RESET_DEFAULT = 32'h0000_0028;
   localparam logic [PC_W-1:0] PC_HALT_INS      = 32'h0000_0073;
   localparam logic [PC_W-1:0] COUNT_MAX        = '1;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } pc_state_e;

   // Force an address onto a 4-byte instruction boundary.
   function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
      return {addr[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side bundle between the PC sequencer and its environment.
//   stall, redirect, target, ins          : environment -> sequencer
//   PCin, fetch_valid, halted, misaligned,
//   fetch_count                           : sequencer -> environment
// master = environment (yIF / branch unit / harness), slave = sequencer.
interface pc_sequencer_if;
   import pc_pkg::*;

   logic            stall;
   logic            redirect;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] ins;
   logic [PC_W-1:0] PCin;
   logic            fetch_valid;
   logic            halted;
   logic            misaligned;
   logic [PC_W-1:0] fetch_count;

   modport master (
      output stall, redirect, target, ins,
      input  PCin, fetch_valid, halted, misaligned, fetch_count
   );

   modport slave (
      input  stall, redirect, target, ins,
      output PCin, fetch_valid, halted, misaligned, fetch_count
   );

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux: combinational next-PC select.
//   state     : current sequencer state
//   pc        : current PC
//   stall     : hold request from downstream
//   redirect  : take target as the next PC
//   halt_hit  : accepted fetch is the halting instruction
//   target    : redirect address (byte offset bits discarded)
//   pc_next_c : selected next PC
module pc_next_mux
   import pc_pkg::*;
(
   input  pc_state_e       state,
   input  logic [PC_W-1:0] pc,
   input  logic            stall,
   input  logic            redirect,
   input  logic            halt_hit,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc_next_c
);

   // Priority: not running > redirect > stall/halt hold > sequential step.
   // A halting fetch holds so PCin stays frozen on the halt instruction.
   always_comb begin
      pc_next_c = pc;
      if (state != ST_RUN) begin
         pc_next_c = pc;
      end else if (redirect) begin
         pc_next_c = word_align(target);
      end else if (stall || halt_hit) begin
         pc_next_c = pc;
      end else begin
         pc_next_c = pc + PC_STEP;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC stage feeding the instruction-fetch unit.
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : pc_sequencer_if.slave
//             in : stall, redirect, target, ins
//             out: PCin (registered), fetch_valid (decoded from state),
//                  halted, misaligned (sticky), fetch_count (saturating)
// Parameters:
//   RESET_PC    : PC loaded on reset
//   HALT_INS    : instruction word that stops fetch
//   COUNT_RESET : fetch counter value loaded on reset (normally zero)
module pc_sequencer
   import pc_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC    = PC_RESET_DEFAULT,
   parameter logic [PC_W-1:0] HALT_INS    = PC_HALT_INS,
   parameter logic [PC_W-1:0] COUNT_RESET = '0
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);

   pc_state_e       state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            halted_q, halted_d;
   logic            misaligned_q, misaligned_d;
   logic [PC_W-1:0] count_q, count_d;

   logic            fetch_valid_c;
   logic            accept_c;
   logic            halt_hit_c;

   pc_next_mux u_next (
      .state     (state_q),
      .pc        (pc_q),
      .stall     (bus.stall),
      .redirect  (bus.redirect),
      .halt_hit  (halt_hit_c),
      .target    (bus.target),
      .pc_next_c (pc_d)
   );

   // State register and datapath flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         halted_q     <= 1'b0;
         misaligned_q <= 1'b0;
         count_q      <= COUNT_RESET;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         halted_q     <= halted_d;
         misaligned_q <= misaligned_d;
         count_q      <= count_d;
      end
   end

   // Next-state, sticky flag and counter update.
   always_comb begin
      state_d       = state_q;
      halted_d      = halted_q;
      misaligned_d  = misaligned_q;
      count_d       = count_q;

      fetch_valid_c = (state_q == ST_RUN);
      // A redirect squashes the fetch in its cycle, including a halt word.
      accept_c      = fetch_valid_c && !bus.stall && !bus.redirect;
      halt_hit_c    = accept_c && (bus.ins == HALT_INS);

      unique case (state_q)
         ST_BOOT: state_d = ST_RUN;
         ST_RUN: begin
            if (halt_hit_c) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_BOOT;
      endcase

      if (fetch_valid_c && bus.redirect && (bus.target[1:0] != 2'b00)) begin
         misaligned_d = 1'b1;
      end

      if (accept_c && (count_q != COUNT_MAX)) begin
         count_d = count_q + PC_W'(1);
      end
   end

   assign bus.PCin        = pc_q;
   assign bus.fetch_valid = fetch_valid_c;
   assign bus.halted      = halted_q;
   assign bus.misaligned  = misaligned_q;
   assign bus.fetch_count = count_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage directly upstream of the instruction-fetch unit (yIF). Holds the architectural PC, drives yIF's `PCin` each cycle, and advances by +4, redirects to a branch/jump target, holds on stall, or halts on a halt instruction. It replaces the testbench-level `PCin = PCp4` loop with synthesizable sequencing and keeps a fetched-instruction count for the lab harness.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0028: PC loaded on reset (program entry point).
- `HALT_INS`, default 32'h0000_0073 (ecall): instruction word that halts fetch.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `stall`  in  1  downstream not ready; hold the PC.
- `redirect`  in  1  take `target` as the next PC.
- `target`  in  32  redirect address from branch/jump resolution.
- `ins`  in  32  instruction returned by yIF for the current `PCin` (same cycle, combinational).
- `PCin`  out  32  current PC, wired to yIF `PCin`.
- `fetch_valid`  out  1  `PCin`/`ins` pair is a real fetch this cycle.
- `halted`  out  1  sequencer is in HALT.
- `misaligned`  out  1  sticky; a redirect target had nonzero bits [1:0].
- `fetch_count`  out  32  number of accepted fetches, saturating.

## Operation
- FSM states: BOOT, RUN, HALT.
  - reset → BOOT.
  - BOOT → RUN unconditionally after one cycle.
  - RUN → HALT when an accepted fetch has `ins == HALT_INS`.
  - HALT is left only by reset.
- Reset values: `PCin = RESET_PC`, `fetch_valid = 0`, `halted = 0`, `misaligned = 0`, `fetch_count = 0`, state BOOT.
- `fetch_valid = 1` iff state is RUN. It is combinational from state.
- An accepted fetch occurs when `fetch_valid && !stall && !redirect`.
- Next-PC priority, highest first:
  1. reset
  2. state HALT or BOOT: hold
  3. redirect: `{target[31:2], 2'b00}`
  4. stall: hold
  5. PC + 4
- Redirect overrides stall.
- Redirect in the same cycle as `ins == HALT_INS`: the halt instruction is squashed and there is no HALT transition.
- Redirect while in BOOT or HALT is ignored.
- `misaligned` sets when `redirect` is accepted in RUN with `target[1:0] != 0`. It stays set until reset.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- `fetch_count` increments by 1 per accepted fetch and saturates at 32'hFFFF_FFFF. The halting instruction itself counts.

## Timing
- All outputs are registered except `fetch_valid`, which is decoded from the state register.
- Latency: a redirect asserted in cycle n makes `PCin = target` in cycle n+1.
- First fetch: `PCin = RESET_PC` with `fetch_valid = 1` in the second cycle after reset deasserts (one BOOT cycle).
- Stall holds `PCin`, the state and the count for every stalled cycle. There is no limit on stall length.
- HALT is visible (`halted = 1`, `fetch_valid = 0`) the cycle after the halting fetch. `PCin` then stays frozen at the halt instruction's address.
- Reset mid-operation: reset wins over every input in that cycle. The next cycle shows the reset values.

## Structure
- Shared package `pc_pkg`:
  - state enum (BOOT, RUN, HALT)
  - constant `PC_STEP = 4`
  - default `RESET_PC`
  - `HALT_INS` encoding
- Sub-module `pc_next_mux`: combinational next-PC priority select and +4 adder.
- The top level holds the FSM, the PC register, the `misaligned` flag and the counter.

## Test plan
- Reset with `RESET_PC = 32'h28`, no stall, ROM with no halt → BOOT for 1 cycle, then `PCin` = 28, 2C, 30, ... and `fetch_count` = 1, 2, 3 on successive cycles.
- Stall asserted for 3 cycles at `PCin = 32'h30` → `PCin` stays 30 and `fetch_count` is held. Resumes at 34 after stall drops.
- `redirect = 1`, `target = 32'h100` while `stall = 1` → next `PCin = 32'h100` and the count is not incremented. Separately, `target = 32'h102` → `PCin = 32'h100` and `misaligned = 1`.
- `ins = 32'h0000_0073` at `PCin = 32'h40` → next cycle `halted = 1`, `fetch_valid = 0`, `PCin = 32'h40`. A later redirect is ignored. Reset returns `PCin` to 28.
- Halt instruction together with `redirect` to 32'h200 → no halt, and `PCin = 32'h200`.
- Force `PCin = 32'hFFFF_FFFC` via redirect → the next accepted fetch gives `PCin = 0`. Preload the counter to 32'hFFFF_FFFE → it saturates at 32'hFFFF_FFFF.
